id_decode_stage: RTL and testbench

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

---
 rtl/id_decode_stage.sv | 179 +++++++++++++++++
 tb/tb_id_decode_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// Instruction decode stage: registers decoded fields of each accepted instruction and
// presents them to execute via a valid/ready handshake. A halt instruction (opcode 00000)
// moves the stage to HALTED, which blocks further input until flush or rst.
// Optional feature macro: ID_SKID_BUFFER_EN selects a two-entry (main + skid) buffer with a
// registered in_ready; when undefined, a single entry is used and in_ready depends on out_ready.
module id_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [4:0]  out_opcode,
  output logic [1:0]  out_funct,
  output logic [10:0] out_imm,
  output logic [15:0] out_pc,
  output logic [2:0]  out_rs,
  output logic [2:0]  out_rt,
  output logic [2:0]  out_rd,
  output logic        out_halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted
);

  typedef enum logic {StRun, StHalted} state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [1:0]  funct;
    logic [10:0] imm;
    logic [15:0] pc;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic        halt;
  } entry_t;

  // Field extraction and destination-register selection for one instruction.
  function automatic entry_t decode(input logic [15:0] instr, input logic [15:0] pc);
    entry_t e;
    e.opcode = instr[15:11];
    e.funct  = instr[1:0];
    e.imm    = instr[10:0];
    e.pc     = pc;
    e.rs     = instr[10:8];
    e.rt     = instr[7:5];
    e.halt   = (instr[15:11] == 5'b00000);
    casez (instr[15:11])
      // 10010 writes its source register, so it is kept apart from the other 100xx ops
      5'b11000, 5'b10010:                      e.rd = instr[10:8];
      5'b11011, 5'b11010, 5'b111??:            e.rd = instr[4:2];
      5'b010??, 5'b101??, 5'b10000, 5'b10001,
      5'b10011:                                e.rd = instr[7:5];
      5'b0011?:                                e.rd = 3'b111;
      default:                                 e.rd = 3'b000;
    endcase
    return e;
  endfunction

  state_e state_q, state_d;
  entry_t main_q, main_d;
  logic   valid_q, valid_d;
  logic   accept, drain;

`ifdef ID_SKID_BUFFER_EN
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic        in_ready_q, in_ready_d;

  // Registered ready: no path from out_ready; rst forces it low in the reset cycle.
  assign in_ready = in_ready_q & ~rst;
`else
  // Single entry: room exists when empty or draining this cycle.
  assign in_ready = ~rst & (state_q == StRun) & (~valid_q | out_ready);
`endif

  assign accept = in_valid & in_ready & ~flush;
  assign drain  = valid_q & out_ready;

  // Next-state for the buffer entries and the RUN/HALTED state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    valid_d = valid_q;
`ifdef ID_SKID_BUFFER_EN
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
`endif
    if (flush) begin
      state_d = StRun;
      valid_d = 1'b0;
`ifdef ID_SKID_BUFFER_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
      if (accept && in_instr[15:11] == 5'b00000) begin
        state_d = StHalted;
      end
`ifdef ID_SKID_BUFFER_EN
      if (drain || !valid_q) begin
        if (skid_valid_q) begin
          // in_ready was low, so nothing new can arrive while the skid entry moves up
          main_d       = decode(skid_instr_q, skid_pc_q);
          valid_d      = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d  = decode(in_instr, in_pc);
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end
`else
      if (accept) begin
        main_d  = decode(in_instr, in_pc);
        valid_d = 1'b1;
      end else if (drain) begin
        valid_d = 1'b0;
      end
`endif
    end
    // out_halt only ever appears together with out_valid
    if (!valid_d) begin
      main_d.halt = 1'b0;
    end
  end

`ifdef ID_SKID_BUFFER_EN
  // Ready for next cycle: skid slot free and not halted.
  always_comb begin
    in_ready_d = ~skid_valid_d & (state_d == StRun);
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      main_q  <= '0;
      valid_q <= 1'b0;
`ifdef ID_SKID_BUFFER_EN
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= valid_d;
`ifdef ID_SKID_BUFFER_EN
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign out_opcode = main_q.opcode;
  assign out_funct  = main_q.funct;
  assign out_imm    = main_q.imm;
  assign out_pc     = main_q.pc;
  assign out_rs     = main_q.rs;
  assign out_rt     = main_q.rt;
  assign out_rd     = main_q.rd;
  assign out_halt   = main_q.halt;
  assign out_valid  = valid_q;
  assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: a queue model of held instructions plus literal spot checks.
module tb_id_decode_stage;

`ifdef ID_SKID_BUFFER_EN
  localparam int Cap = 2;
`else
  localparam int Cap = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_instr, in_pc;
  logic        in_ready;
  logic [4:0]  out_opcode;
  logic [1:0]  out_funct;
  logic [10:0] out_imm;
  logic [15:0] out_pc;
  logic [2:0]  out_rs, out_rt, out_rd;
  logic        out_halt, out_valid, halted;

  id_decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_opcode(out_opcode),
    .out_funct (out_funct),
    .out_imm   (out_imm),
    .out_pc    (out_pc),
    .out_rs    (out_rs),
    .out_rt    (out_rt),
    .out_rd    (out_rd),
    .out_halt  (out_halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  bit          chk_en = 0;
  bit          m_halted = 0;
  logic [31:0] m_q[$];   // {pc, instr} of every held instruction, oldest first
  logic [15:0] pc_ctr = 16'h0100;

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination register from the opcode table, by opcode number.
  function automatic logic [2:0] exp_rd(input logic [15:0] i);
    int op;
    op = int'(i[15:11]);
    if (op == 27 || op == 26 || op >= 28) return i[4:2];
    if (op == 24 || op == 18) return i[10:8];
    if ((op >= 8 && op <= 11) || (op >= 16 && op <= 23)) return i[7:5];
    if (op == 6 || op == 7) return 3'b111;
    return 3'b000;
  endfunction

  function automatic bit model_ready();
    if (rst || m_halted) return 1'b0;
    if (Cap == 2) return m_q.size() < 2;
    return (m_q.size() == 0) || out_ready;
  endfunction

  // Model update on each active edge.
  always @(posedge clk) begin
    bit acc, drn;
    acc = in_valid && model_ready();
    drn = (m_q.size() > 0) && out_ready;
    if (rst || flush) begin
      m_q.delete();
      m_halted = 0;
    end else begin
      if (drn) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back({in_pc, in_instr});
        acc_cnt++;
        if (in_instr[15:11] == 5'b00000) m_halted = 1;
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] ei, ep;
      lit("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      lit("in_ready", 64'(in_ready), 64'(model_ready()));
      lit("halted", 64'(halted), 64'(m_halted));
      if (m_q.size() > 0) begin
        ei = m_q[0][15:0];
        ep = m_q[0][31:16];
        lit("fields", 64'({out_opcode, out_funct, out_imm, out_pc, out_rs, out_rt, out_rd,
                           out_halt}),
            64'({ei[15:11], ei[1:0], ei[10:0], ep, ei[10:8], ei[7:5], exp_rd(ei),
                 ei[15:11] == 5'b00000}));
      end else begin
        lit("out_halt_idle", 64'(out_halt), 64'(0));
      end
    end
  end

  task automatic step(input logic [15:0] instr, input logic v, input logic ordy,
                      input logic fl);
    in_instr  = instr;
    in_pc     = pc_ctr;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
    pc_ctr = pc_ctr + 16'd2;
  endtask

  logic [15:0] tbl[11];
  logic [31:0] vpat, rpat;
  int          base;

  initial begin
    tbl = '{16'h4125, 16'hD948, 16'hC2FF, 16'h3000, 16'h9400, 16'h3B00, 16'hE49C,
            16'hA8E0, 16'h8123, 16'h6ABC, 16'h2345};
    rst = 1'b1;
    step(16'h0, 0, 1, 0);
    chk_en = 1;
    step(16'h0, 0, 1, 0);
    lit("rst_valid", 64'(out_valid), 64'(0));
    lit("rst_pc", 64'(out_pc), 64'(0));
    lit("rst_halted", 64'(halted), 64'(0));
    rst = 1'b0;
    #1;
    lit("ready_after_rst", 64'(in_ready), 64'(1));

    // addi, one-cycle latency
    step(16'h4125, 1, 1, 0);
    lit("addi_valid", 64'(out_valid), 64'(1));
    lit("addi_op", 64'(out_opcode), 64'(5'b01000));
    lit("addi_regs", 64'({out_rs, out_rt, out_rd}), 64'({3'd1, 3'd1, 3'd1}));
    lit("addi_imm", 64'(out_imm), 64'(11'h125));
    step(16'hD948, 1, 1, 0);
    lit("r_regs", 64'({out_rs, out_rt, out_rd}), 64'({3'd1, 3'd2, 3'd2}));
    step(16'hC2FF, 1, 1, 0);
    lit("lbi_rd", 64'(out_rd), 64'(2));
    lit("lbi_imm", 64'(out_imm[7:0]), 64'(8'hFF));
    step(16'h3000, 1, 1, 0);
    lit("jal_rd", 64'(out_rd), 64'(7));
    step(16'h9400, 1, 1, 0);
    lit("slbi_rd", 64'(out_rd), 64'(4));
    step(16'h0, 0, 1, 0);

    // Stall with back-to-back inputs
    base = acc_cnt;
    step(16'h4125, 1, 0, 0);
    step(16'hD948, 1, 0, 0);
    step(16'hC2FF, 1, 0, 0);
    lit("stall_accepts", 64'(acc_cnt - base), 64'(Cap));
    lit("stall_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 4; i++) step(16'h0, 0, 1, 0);

    // Halt then blocked addi, then flush
    step(16'h0000, 1, 1, 0);
    lit("halt_out", 64'({out_valid, out_halt}), 64'(2'b11));
    lit("halt_state", 64'(halted), 64'(1));
    base = acc_cnt;
    step(16'h4125, 1, 1, 0);
    step(16'h4125, 1, 1, 0);
    lit("halt_blocks", 64'(acc_cnt - base), 64'(0));
    lit("halt_ready", 64'(in_ready), 64'(0));
    step(16'h0, 0, 1, 1);
    lit("flush_unhalt", 64'(halted), 64'(0));
    lit("flush_ready", 64'(in_ready), 64'(1));

    // Flush with entries held and same-cycle accept
    step(16'h4125, 1, 0, 0);
    step(16'hD948, 1, 0, 0);
    step(16'hC2FF, 1, 0, 1);
    lit("flush_held", 64'(out_valid), 64'(0));
    step(16'h3000, 1, 1, 1);
    lit("flush_accept", 64'(out_valid), 64'(0));
    for (int i = 0; i < 3; i++) step(16'h0, 0, 1, 0);

    // Reset mid-stall
    step(16'hE49C, 1, 0, 0);
    step(16'h0, 0, 0, 0);
    rst = 1'b1;
    step(16'h0, 0, 0, 0);
    lit("rst_stall_valid", 64'(out_valid), 64'(0));
    lit("rst_stall_pc", 64'(out_pc), 64'(0));
    rst = 1'b0;
    step(16'h4125, 1, 1, 0);
    lit("rst_run", 64'(out_valid), 64'(1));

    // Mixed valid/ready patterns over the opcode table
    vpat = 32'hB7DE_6F3B;
    rpat = 32'h9A5C_E3B6;
    for (int i = 0; i < 32; i++) step(tbl[i % 11], vpat[i], rpat[i], 0);
    for (int i = 0; i < 4; i++) step(16'h0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
